// File: rtl/al4s3b_fpga_wb_decoder_pkg.sv
// Shared aperture codes, slave indices and FSM encodings for the AL4S3B FPGA
// Wishbone decoder.
package al4s3b_fpga_wb_decoder_pkg;

   localparam logic [2:0] AP_REGS   = 3'b000;
   localparam logic [2:0] AP_SLAVE1 = 3'b001;
   localparam logic [2:0] AP_SLAVE2 = 3'b010;
   localparam logic [2:0] AP_QL     = 3'b111;

   localparam logic [1:0] IDX_REGS   = 2'd0;
   localparam logic [1:0] IDX_SLAVE1 = 2'd1;
   localparam logic [1:0] IDX_SLAVE2 = 2'd2;
   localparam logic [1:0] IDX_QL     = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   typedef struct packed {
      logic       unmapped;
      logic [1:0] idx;
   } decode_t;

   // Unmapped apertures report the reserved block's index so its timeout ack completes them.
   function automatic decode_t decode_aperture(input logic [2:0] ap);
      decode_t d;
      d.unmapped = 1'b0;
      d.idx      = IDX_QL;
      case (ap)
         AP_REGS:   d.idx = IDX_REGS;
         AP_SLAVE1: d.idx = IDX_SLAVE1;
         AP_SLAVE2: d.idx = IDX_SLAVE2;
         AP_QL:     d.idx = IDX_QL;
         default:   d.unmapped = 1'b1;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/al4s3b_fpga_wb_ack_mux.sv
// Selects the ack and read data of the registered slave index and flags acks
// coming from any other slave.
module al4s3b_fpga_wb_ack_mux #(
   parameter int DATAWIDTH = 32
) (
   input  logic [1:0]             sel,
   input  logic [3:0]             ack_in,
   input  logic [4*DATAWIDTH-1:0] dat_in,
   output logic                   ack_sel,
   output logic                   ack_other,
   output logic [DATAWIDTH-1:0]   dat_sel
);

   logic [3:0] sel_onehot;

   always_comb begin
      sel_onehot = 4'b0001 << sel;
      ack_sel    = ack_in[sel];
      ack_other  = |(ack_in & ~sel_onehot);
      dat_sel    = dat_in[sel*DATAWIDTH +: DATAWIDTH];
   end

endmodule

// File: rtl/al4s3b_fpga_wb_decoder.sv
// Wishbone aperture decoder: routes one bridge cycle at a time to a slave,
// returns its ack/data one cycle later and tracks unmapped and stray acks.
module al4s3b_fpga_wb_decoder
   import al4s3b_fpga_wb_decoder_pkg::*;
#(
   parameter int ADDRWIDTH = 10,
   parameter int DATAWIDTH = 32,
   parameter int CNTWIDTH  = 8
) (
   input  logic                   WBs_CLK_i,
   input  logic                   WBs_RSTn_i,
   input  logic [ADDRWIDTH-1:0]   WBs_ADR_i,
   input  logic                   WBs_CYC_i,
   input  logic                   WBs_STB_i,
   output logic [3:0]             WBs_CYC_o,
   output logic                   WBs_STB_o,
   input  logic [3:0]             WBs_ACK_i,
   input  logic [4*DATAWIDTH-1:0] WBs_DAT_i,
   output logic                   WBs_ACK_o,
   output logic [DATAWIDTH-1:0]   WBs_DAT_o,
   output logic                   WBs_ACK_IP_o,
   output logic [CNTWIDTH-1:0]    Unmapped_Cnt_o,
   output logic                   Stray_Ack_o
);

   state_t                state;
   state_t                state_next;
   decode_t               dec;
   logic [1:0]            idx;
   logic                  unmapped;
   logic                  accept;
   logic                  capture;
   logic                  ack_sel;
   logic                  ack_other;
   logic [DATAWIDTH-1:0]  dat_sel;
   logic                  unused_adr;

   assign dec          = decode_aperture(WBs_ADR_i[ADDRWIDTH-1 -: 3]);
   assign unused_adr   = ^WBs_ADR_i[ADDRWIDTH-4:0];
   assign WBs_ACK_IP_o = |WBs_ACK_i[2:0];
   assign WBs_STB_o    = (state == ST_ACTIVE) & WBs_STB_i;

   al4s3b_fpga_wb_ack_mux #(
      .DATAWIDTH (DATAWIDTH)
   ) u_ack_mux (
      .sel       (idx),
      .ack_in    (WBs_ACK_i),
      .dat_in    (WBs_DAT_i),
      .ack_sel   (ack_sel),
      .ack_other (ack_other),
      .dat_sel   (dat_sel)
   );

   // Next-state logic; an abort takes priority over a simultaneous ack.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      capture    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (WBs_CYC_i && WBs_STB_i) begin
               state_next = ST_ACTIVE;
               accept     = 1'b1;
            end else begin
               state_next = ST_IDLE;
            end
         end
         ST_ACTIVE: begin
            if (!WBs_CYC_i) begin
               state_next = ST_IDLE;
            end else if (ack_sel) begin
               state_next = ST_DONE;
               capture    = 1'b1;
            end else begin
               state_next = ST_ACTIVE;
            end
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // State, registered selection and bridge-facing outputs.
   always_ff @(posedge WBs_CLK_i or negedge WBs_RSTn_i) begin
      if (!WBs_RSTn_i) begin
         state          <= ST_IDLE;
         idx            <= IDX_REGS;
         unmapped       <= 1'b0;
         WBs_CYC_o      <= 4'b0000;
         WBs_ACK_o      <= 1'b0;
         WBs_DAT_o      <= '0;
         Unmapped_Cnt_o <= '0;
         Stray_Ack_o    <= 1'b0;
      end else begin
         state     <= state_next;
         WBs_ACK_o <= capture;
         if (accept) begin
            idx       <= dec.idx;
            unmapped  <= dec.unmapped;
            WBs_CYC_o <= dec.unmapped ? 4'b0000 : (4'b0001 << dec.idx);
         end else if (state_next != ST_ACTIVE) begin
            WBs_CYC_o <= 4'b0000;
         end
         if (capture) begin
            WBs_DAT_o <= dat_sel;
         end
         if (capture && unmapped && (Unmapped_Cnt_o != {CNTWIDTH{1'b1}})) begin
            Unmapped_Cnt_o <= Unmapped_Cnt_o + CNTWIDTH'(1);
         end
         if (((state == ST_IDLE) && (|WBs_ACK_i)) || ((state == ST_ACTIVE) && ack_other)) begin
            Stray_Ack_o <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_al4s3b_fpga_wb_decoder.sv
// Directed, table-driven bench for the AL4S3B FPGA Wishbone decoder.
module tb_al4s3b_fpga_wb_decoder;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [9:0]   adr;
   logic         cyc;
   logic         stb;
   logic [3:0]   cyc_o;
   logic         stb_o;
   logic [3:0]   ack_in;
   logic [127:0] dat_in;
   logic         ack_o;
   logic [31:0]  dat_o;
   logic         ack_ip;
   logic [7:0]   cnt;
   logic         stray;

   int errors = 0;
   int checks = 0;
   logic [7:0] exp_cnt;

   typedef struct {
      logic [9:0]  adr;
      logic [3:0]  ack;
      int          slot;
      int          delay;
      logic [31:0] dat;
      logic [3:0]  exp_cyc;
      logic        exp_ip;
      logic        unm;
   } vec_t;

   vec_t vecs[8];

   always #5 clk = ~clk;

   al4s3b_fpga_wb_decoder dut (
      .WBs_CLK_i      (clk),
      .WBs_RSTn_i     (rst_n),
      .WBs_ADR_i      (adr),
      .WBs_CYC_i      (cyc),
      .WBs_STB_i      (stb),
      .WBs_CYC_o      (cyc_o),
      .WBs_STB_o      (stb_o),
      .WBs_ACK_i      (ack_in),
      .WBs_DAT_i      (dat_in),
      .WBs_ACK_o      (ack_o),
      .WBs_DAT_o      (dat_o),
      .WBs_ACK_IP_o   (ack_ip),
      .Unmapped_Cnt_o (cnt),
      .Stray_Ack_o    (stray)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_dat(input int slot, input logic [31:0] d);
      for (int s = 0; s < 4; s++) dat_in[s*32 +: 32] = 32'hBAD00000 | 32'(s);
      dat_in[slot*32 +: 32] = d;
   endtask

   task automatic run_vec(input vec_t v);
      adr = v.adr; cyc = 1'b1; stb = 1'b1;
      tick();
      check("cyc_o", 32'(cyc_o), 32'(v.exp_cyc));
      check("stb_o", 32'(stb_o), 32'd1);
      check("ack_early", 32'(ack_o), 32'd0);
      repeat (v.delay) tick();
      check("ack_wait", 32'(ack_o), 32'd0);
      ack_in = v.ack;
      set_dat(v.slot, v.dat);
      #1;
      check("ack_ip", 32'(ack_ip), 32'(v.exp_ip));
      tick();
      check("ack_o", 32'(ack_o), 32'd1);
      check("dat_o", dat_o, v.dat);
      check("cyc_done", 32'(cyc_o), 32'd0);
      ack_in = 4'b0000; cyc = 1'b0; stb = 1'b0;
      set_dat(0, 32'h0);
      if (v.unm) exp_cnt = (exp_cnt == 8'hFF) ? 8'hFF : exp_cnt + 8'd1;
      tick();
      check("ack_pulse", 32'(ack_o), 32'd0);
      check("dat_hold", dat_o, v.dat);
      check("cnt", 32'(cnt), 32'(exp_cnt));
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{10'h005, 4'b0001, 0, 3, 32'h12345678, 4'b0001, 1'b1, 1'b0};
      vecs[1] = '{10'h3FE, 4'b1000, 3, 2, 32'h00000100, 4'b1000, 1'b0, 1'b0};
      vecs[2] = '{10'h180, 4'b1000, 3, 7, 32'hDEFFABAC, 4'b0000, 1'b0, 1'b1};
      vecs[3] = '{10'h080, 4'b0010, 1, 1, 32'hCAFE0001, 4'b0010, 1'b1, 1'b0};
      vecs[4] = '{10'h100, 4'b0100, 2, 0, 32'hCAFE0002, 4'b0100, 1'b1, 1'b0};
      vecs[5] = '{10'h200, 4'b1000, 3, 4, 32'h0BAD0200, 4'b0000, 1'b0, 1'b1};
      vecs[6] = '{10'h2FF, 4'b1000, 3, 1, 32'h0BAD02FF, 4'b0000, 1'b0, 1'b1};
      vecs[7] = '{10'h37F, 4'b1000, 3, 2, 32'h0BAD037F, 4'b0000, 1'b0, 1'b1};

      rst_n = 1'b0; adr = 10'h000; cyc = 1'b0; stb = 1'b0;
      ack_in = 4'b0000; dat_in = 128'h0; exp_cnt = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      check("rst_cyc", 32'(cyc_o), 32'd0);
      check("rst_ack", 32'(ack_o), 32'd0);
      check("rst_dat", dat_o, 32'd0);
      check("rst_cnt", 32'(cnt), 32'd0);
      check("rst_stray", 32'(stray), 32'd0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 8; i++) run_vec(vecs[i]);

      // Abort together with the selected ack: no ack, data unchanged.
      adr = 10'h005; cyc = 1'b1; stb = 1'b1;
      tick();
      cyc = 1'b0; stb = 1'b0; ack_in = 4'b0001;
      set_dat(0, 32'hAAAA5555);
      tick();
      check("abort_ack", 32'(ack_o), 32'd0);
      check("abort_dat", dat_o, 32'h0BAD037F);
      check("abort_cyc", 32'(cyc_o), 32'd0);
      ack_in = 4'b0000;
      tick();
      check("abort_ack2", 32'(ack_o), 32'd0);
      check("stray_clear", 32'(stray), 32'd0);

      // Slave2 acks during a slave1 access.
      adr = 10'h080; cyc = 1'b1; stb = 1'b1;
      tick();
      ack_in = 4'b0100;
      set_dat(2, 32'h55550000);
      tick();
      check("stray_set", 32'(stray), 32'd1);
      check("stray_noack", 32'(ack_o), 32'd0);
      check("stray_cyc", 32'(cyc_o), 32'b0010);
      ack_in = 4'b0010;
      set_dat(1, 32'h11112222);
      tick();
      check("stray_ack", 32'(ack_o), 32'd1);
      check("stray_dat", dat_o, 32'h11112222);
      ack_in = 4'b0000; cyc = 1'b0; stb = 1'b0;
      tick();
      check("stray_pulse", 32'(ack_o), 32'd0);
      check("stray_sticky", 32'(stray), 32'd1);

      // Asynchronous reset in the middle of an active access.
      adr = 10'h100; cyc = 1'b1; stb = 1'b1;
      tick();
      check("pre_rst_cyc", 32'(cyc_o), 32'b0100);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_cyc", 32'(cyc_o), 32'd0);
      check("arst_stb", 32'(stb_o), 32'd0);
      check("arst_dat", dat_o, 32'd0);
      check("arst_stray", 32'(stray), 32'd0);
      check("arst_cnt", 32'(cnt), 32'd0);
      cyc = 1'b0; stb = 1'b0;
      #1;
      rst_n = 1'b1;
      exp_cnt = 8'h00;
      tick();
      run_vec(vecs[0]);

      // Any ack while idle is stray.
      check("idle_stray0", 32'(stray), 32'd0);
      ack_in = 4'b0001;
      tick();
      ack_in = 4'b0000;
      check("idle_stray1", 32'(stray), 32'd1);
      check("idle_noack", 32'(ack_o), 32'd0);
      tick();

      // Counter saturation.
      for (int i = 0; i < 300; i++) run_vec(vecs[2]);
      check("cnt_sat", 32'(cnt), 32'hFF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
